// File: rtl/cellram_responder.sv
// -----------------------------------------------------------------------------
// cellram_responder
//
// Clocked stand-in for an asynchronous-mode CellRAM device.  It backs a small
// word array, measures the controller's strobe timing in clock cycles, and
// raises a sticky Violation_o flag when the controller breaks the access rules.
// All inputs are sampled on the rising edge of Clock_i with no synchronizers.
// The controller and this block share that clock.
//
// State table
//   state        | meaning
//   -------------+------------------------------------------------------------
//   S_IDLE       | no access; decode CE#/WE#/OE#/CRE for a new access
//   S_READ_WAIT  | read latched, counting down the access latency, bus Hi-Z
//   S_READ_DRIVE | driving mem[addr] on MemDB until the read ends or addr moves
//   S_WRITE      | array write in progress, counting WE# low cycles
//   S_CFG_WRITE  | BCR write in progress (CRE=1), counting WE# low cycles
//
// Ports
//   Clock_i       system clock, rising-edge sampling
//   Reset_i       asynchronous active-high reset
//   MemAdr_i      word address; bits above ADDR_BITS-1 are ignored for the array
//   MemDB_io      16-bit data bus, driven only in S_READ_DRIVE
//   RamCEn_i      chip enable (active low)
//   RamOEn_i      output enable (active low)
//   RamWEn_i      write enable (active low)
//   RamADVn_i     address valid (active low); must be low for every access
//   RamUBn_i      upper-byte enable (active low)
//   RamLBn_i      lower-byte enable (active low)
//   RamCRE_i      configuration-register enable (active high)
//   ConfigReg_o   current bus configuration register
//   WriteCount_o  committed array writes (wraps)
//   ReadCount_o   completed read accesses (wraps)
//   Violation_o   sticky protocol-violation flag
// -----------------------------------------------------------------------------
module cellram_responder #(
  parameter int          ADDR_BITS    = 10,
  parameter int          READ_LATENCY = 7,
  parameter int          WRITE_CYCLES = 7,
  parameter logic [15:0] BCR_DEFAULT  = 16'h9D1F
) (
  input  logic        Clock_i,
  input  logic        Reset_i,
  input  logic [22:0] MemAdr_i,
  inout  logic [15:0] MemDB_io,
  input  logic        RamCEn_i,
  input  logic        RamOEn_i,
  input  logic        RamWEn_i,
  input  logic        RamADVn_i,
  input  logic        RamUBn_i,
  input  logic        RamLBn_i,
  input  logic        RamCRE_i,
  output logic [15:0] ConfigReg_o,
  output logic [15:0] WriteCount_o,
  output logic [15:0] ReadCount_o,
  output logic        Violation_o
);

  localparam int         DEPTH   = 1 << ADDR_BITS;
  localparam logic [3:0] RD_LOAD = 4'(READ_LATENCY - 1);
  localparam logic [3:0] WR_MIN  = 4'(WRITE_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ_WAIT,
    S_READ_DRIVE,
    S_WRITE,
    S_CFG_WRITE
  } state_t;

  state_t                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;
  logic [15:0]            wdata_q, wdata_d;
  logic                   ub_q, ub_d;
  logic                   lb_q, lb_d;
  logic                   adr_err_q, adr_err_d;
  logic [15:0]            bcr_q, bcr_d;
  logic [15:0]            wcnt_q, wcnt_d;
  logic [15:0]            rcnt_q, rcnt_d;
  logic                   viol_q, viol_d;
  logic                   mem_we;

  logic [15:0]            mem_q [DEPTH];
  logic [15:0]            rdata_q;
  logic                   db_oe;

  logic [ADDR_BITS-1:0]   adr_used;
  logic [3:0]             cnt_sat_inc;
  logic                   unused_adr_bits;

  assign adr_used        = MemAdr_i[ADDR_BITS-1:0];
  assign cnt_sat_inc     = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
  assign unused_adr_bits = ^MemAdr_i[22:16];

  // The bus enable comes straight from the state register, so an asynchronous
  // reset releases MemDB without waiting for a clock edge.
  assign db_oe    = (state_q == S_READ_DRIVE);
  assign MemDB_io = db_oe ? rdata_q : {16{1'bz}};

  assign ConfigReg_o  = bcr_q;
  assign WriteCount_o = wcnt_q;
  assign ReadCount_o  = rcnt_q;
  assign Violation_o  = viol_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    ub_d      = ub_q;
    lb_d      = lb_q;
    adr_err_d = adr_err_q;
    bcr_d     = bcr_q;
    wcnt_d    = wcnt_q;
    rcnt_d    = rcnt_q;
    viol_d    = viol_q;
    mem_we    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!RamCEn_i) begin
          if (RamADVn_i) viol_d = 1'b1;
          // WE# outranks OE#: a simultaneous OE#/WE# low is a write.
          if (!RamWEn_i) begin
            addr_d    = adr_used;
            ub_d      = RamUBn_i;
            lb_d      = RamLBn_i;
            cnt_d     = 4'd1;
            adr_err_d = 1'b0;
            if (RamCRE_i) begin
              wdata_d = MemAdr_i[15:0];
              state_d = S_CFG_WRITE;
            end else begin
              wdata_d = MemDB_io;
              state_d = S_WRITE;
            end
          end else if (!RamOEn_i) begin
            addr_d  = adr_used;
            cnt_d   = RD_LOAD;
            state_d = S_READ_WAIT;
          end
        end
      end

      S_READ_WAIT: begin
        if (RamCEn_i || RamOEn_i) begin
          state_d = S_IDLE;
        end else if (cnt_q == 4'd0) begin
          state_d = S_READ_DRIVE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      S_READ_DRIVE: begin
        if (RamCEn_i || RamOEn_i || !RamWEn_i) begin
          rcnt_d  = rcnt_q + 16'd1;
          state_d = S_IDLE;
        end else if (adr_used != addr_q) begin
          // A moved address is a fresh read with the full latency.
          rcnt_d  = rcnt_q + 16'd1;
          addr_d  = adr_used;
          cnt_d   = RD_LOAD;
          state_d = S_READ_WAIT;
        end
      end

      S_WRITE, S_CFG_WRITE: begin
        if (RamCEn_i || RamWEn_i) begin
          state_d = S_IDLE;
          if (cnt_q >= WR_MIN && !adr_err_q) begin
            if (state_q == S_WRITE) begin
              mem_we = 1'b1;
              wcnt_d = wcnt_q + 16'd1;
            end else begin
              bcr_d = wdata_q;
            end
          end else begin
            viol_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_sat_inc;
          ub_d  = RamUBn_i;
          lb_d  = RamLBn_i;
          if (state_q == S_WRITE) begin
            wdata_d = MemDB_io;
            if (adr_used != addr_q) begin
              adr_err_d = 1'b1;
              viol_d    = 1'b1;
            end
          end else begin
            // For a BCR write the payload travels on the address bus.
            wdata_d = MemAdr_i[15:0];
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock_i or posedge Reset_i) begin
    if (Reset_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      addr_q    <= '0;
      wdata_q   <= 16'd0;
      ub_q      <= 1'b1;
      lb_q      <= 1'b1;
      adr_err_q <= 1'b0;
      bcr_q     <= BCR_DEFAULT;
      wcnt_q    <= 16'd0;
      rcnt_q    <= 16'd0;
      viol_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      ub_q      <= ub_d;
      lb_q      <= lb_d;
      adr_err_q <= adr_err_d;
      bcr_q     <= bcr_d;
      wcnt_q    <= wcnt_d;
      rcnt_q    <= rcnt_d;
      viol_q    <= viol_d;
    end
  end

  // Array storage survives reset.  The read register follows addr_q, which is
  // stable for the whole wait, so it holds mem[addr] on entry to S_READ_DRIVE.
  always_ff @(posedge Clock_i) begin
    if (mem_we && !ub_q) mem_q[addr_q][15:8] <= wdata_q[15:8];
    if (mem_we && !lb_q) mem_q[addr_q][7:0]  <= wdata_q[7:0];
    rdata_q <= mem_q[addr_q];
  end

endmodule

// File: tb/tb_cellram_responder.sv
module tb_cellram_responder;

  localparam int L  = 7;
  localparam int WC = 7;

  logic        clk;
  logic        rst;
  logic [22:0] MemAdr;
  wire  [15:0] MemDB;
  logic        CEn, OEn, WEn, ADVn, UBn, LBn, CRE;
  logic [15:0] ConfigReg, WriteCount, ReadCount;
  logic        Violation;

  logic [15:0] tb_db;
  logic        tb_db_en;
  assign MemDB = tb_db_en ? tb_db : {16{1'bz}};

  cellram_responder dut (
    .Clock_i     (clk),
    .Reset_i     (rst),
    .MemAdr_i    (MemAdr),
    .MemDB_io    (MemDB),
    .RamCEn_i    (CEn),
    .RamOEn_i    (OEn),
    .RamWEn_i    (WEn),
    .RamADVn_i   (ADVn),
    .RamUBn_i    (UBn),
    .RamLBn_i    (LBn),
    .RamCRE_i    (CRE),
    .ConfigReg_o (ConfigReg),
    .WriteCount_o(WriteCount),
    .ReadCount_o (ReadCount),
    .Violation_o (Violation)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: what the device should hold, at the level of whole accesses.
  logic [15:0] m_mem [1024];
  bit          m_known [1024];
  logic [15:0] m_bcr, m_wc, m_rc;
  bit          m_viol;

  typedef struct { int c; logic [15:0] v; } exp_t;
  exp_t exp_q[$];

  // Monitor: each time the DUT starts driving the bus, pop the expected read
  // and check both the cycle it appeared and the word on the bus.
  bit          oe_prev = 1'b0;
  logic [15:0] cur_val = 16'h0;
  always @(negedge clk) begin
    logic oe;
    oe = dut.db_oe;
    if (oe && !oe_prev) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_drive", 32'(oe), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("drive_start_cycle", 32'(cyc), 32'(e.c));
        chk("read_data", 32'(MemDB), 32'(e.v));
        cur_val = e.v;
      end
    end else if (oe) begin
      chk("read_hold", 32'(MemDB), 32'(cur_val));
    end
    oe_prev = oe;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    CEn = 1'b1; OEn = 1'b1; WEn = 1'b1; ADVn = 1'b1;
    UBn = 1'b1; LBn = 1'b1; CRE = 1'b0; tb_db_en = 1'b0;
  endtask

  task automatic model_reset();
    m_bcr = 16'h9D1F; m_wc = 16'h0; m_rc = 16'h0; m_viol = 1'b0;
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_cfg"},  32'(ConfigReg),  32'(m_bcr));
    chk({tag, "_wc"},   32'(WriteCount), 32'(m_wc));
    chk({tag, "_rc"},   32'(ReadCount),  32'(m_rc));
    chk({tag, "_viol"}, 32'(Violation),  32'(m_viol));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus_idle();
    step();
    step();
    rst = 1'b0;
    model_reset();
    step();
  endtask

  task automatic do_write(input logic [22:0] a, input logic [15:0] d, input logic ub,
                          input logic lb, input int ncyc, input bit cre, input bit oe_lo,
                          input bit chg, input bit adv_hi);
    int idx;
    bit bad_adr;
    idx = int'(a[9:0]);
    bad_adr = chg && (ncyc > 2);
    CEn = 1'b0; WEn = 1'b0; OEn = !oe_lo; ADVn = adv_hi; CRE = cre;
    UBn = ub; LBn = lb; MemAdr = a; tb_db = d; tb_db_en = !oe_lo || 1'b1;
    for (int i = 0; i < ncyc; i++) begin
      if (chg && i == 2) MemAdr = a ^ 23'h1;
      step();
    end
    bus_idle();
    step();
    if (adv_hi) m_viol = 1'b1;
    if (cre) begin
      if (ncyc >= WC) m_bcr = a[15:0];
      else m_viol = 1'b1;
    end else begin
      if (bad_adr) m_viol = 1'b1;
      if (ncyc >= WC && !bad_adr) begin
        if (!ub) m_mem[idx][15:8] = d[15:8];
        if (!lb) m_mem[idx][7:0]  = d[7:0];
        m_known[idx] = m_known[idx] || (!ub && !lb);
        m_wc = m_wc + 16'd1;
      end else begin
        m_viol = 1'b1;
      end
    end
  endtask

  // extra: additional driven cycles beyond the first; chg >= 0 moves the
  // address mid-read; rst_mid asserts reset while the bus is driven.
  task automatic do_read(input logic [22:0] a, input int extra, input int chg,
                         input bit adv_hi, input bit rst_mid);
    exp_t e;
    CEn = 1'b0; OEn = 1'b0; WEn = 1'b1; ADVn = adv_hi; CRE = 1'b0; tb_db_en = 1'b0;
    MemAdr = a;
    if (adv_hi) m_viol = 1'b1;
    e.c = cyc + 1 + L; e.v = m_mem[int'(a[9:0])];
    exp_q.push_back(e);
    repeat (L + 1 + extra) step();
    if (rst_mid) begin
      #2;
      rst = 1'b1;
      #1;
      chk("rst_bus_released", 32'(dut.db_oe), 32'd0);
      bus_idle();
      step();
      rst = 1'b0;
      model_reset();
      step();
      return;
    end
    if (chg >= 0) begin
      MemAdr = {a[22:10], 10'(chg)};
      m_rc = m_rc + 16'd1;
      e.c = cyc + 1 + L; e.v = m_mem[chg];
      exp_q.push_back(e);
      repeat (L + 1 + extra) step();
    end
    bus_idle();
    m_rc = m_rc + 16'd1;
    step();
  endtask

  initial begin
    rst = 1'b1;
    MemAdr = 23'h0; tb_db = 16'h0;
    bus_idle();
    model_reset();
    for (int i = 0; i < 1024; i++) begin m_mem[i] = 16'h0; m_known[i] = 1'b0; end
    repeat (3) step();
    rst = 1'b0;
    step();
    check_state("reset");
    chk("reset_bus", 32'(dut.db_oe), 32'd0);

    do_write(23'd0, 16'd2050, 1'b0, 1'b0, 7, 1'b0, 1'b0, 1'b0, 1'b0);
    do_read(23'd0, 0, -1, 1'b0, 1'b0);
    check_state("basic_wr_rd");

    do_write(23'd3, 16'h5555, 1'b0, 1'b0, 7, 1'b0, 1'b0, 1'b0, 1'b0);
    do_write(23'd3, 16'h0C8E, 1'b0, 1'b0, 5, 1'b0, 1'b0, 1'b0, 1'b0);
    check_state("short_write");
    do_read(23'd3, 1, -1, 1'b0, 1'b0);

    do_write(23'd5, 16'hAAAA, 1'b0, 1'b0, 7, 1'b0, 1'b0, 1'b0, 1'b0);
    do_write(23'd5, 16'h1234, 1'b1, 1'b0, 7, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("byte_mask_model", 32'(m_mem[5]), 32'h0000AA34);
    do_read(23'd5, 0, -1, 1'b0, 1'b0);
    check_state("byte_mask");

    do_write(23'd1, 16'h1111, 1'b0, 1'b0, 7, 1'b0, 1'b0, 1'b0, 1'b0);
    do_write(23'd2, 16'h2222, 1'b0, 1'b0, 7, 1'b0, 1'b0, 1'b0, 1'b0);
    do_read(23'd1, 2, 2, 1'b0, 1'b0);
    check_state("addr_change_read");

    do_write(23'h0011, 16'hFFFF, 1'b0, 1'b0, 7, 1'b1, 1'b0, 1'b0, 1'b0);
    check_state("cfg_write");
    do_read(23'd1, 0, -1, 1'b0, 1'b0);

    do_read(23'd2, 1, -1, 1'b0, 1'b1);
    check_state("rst_during_read");
    do_read(23'd0, 0, -1, 1'b0, 1'b0);
    check_state("retained");

    do_write(23'd7, 16'h7777, 1'b0, 1'b0, 7, 1'b0, 1'b1, 1'b0, 1'b0);
    do_read(23'd7, 0, -1, 1'b0, 1'b0);
    check_state("oe_we_both_low");

    do_write(23'd9, 16'h9999, 1'b0, 1'b0, 7, 1'b0, 1'b0, 1'b0, 1'b0);
    CEn = 1'b0; WEn = 1'b0; ADVn = 1'b0; MemAdr = 23'd9; tb_db = 16'h0BAD; tb_db_en = 1'b1;
    UBn = 1'b0; LBn = 1'b0;
    repeat (8) step();
    #2;
    rst = 1'b1;
    #1;
    bus_idle();
    step();
    rst = 1'b0;
    model_reset();
    step();
    do_read(23'd9, 0, -1, 1'b0, 1'b0);
    check_state("rst_during_write");

    do_write(23'd4, 16'h4444, 1'b0, 1'b0, 8, 1'b0, 1'b0, 1'b1, 1'b0);
    check_state("write_addr_change");

    do_reset();
    do_read(23'd5, 0, -1, 1'b1, 1'b0);
    check_state("adv_high");

    // Randomized phase over a small address window with random high bits.
    do_reset();
    for (int i = 0; i < 16; i++)
      do_write({13'($urandom), 10'(i)}, 16'($urandom), 1'b0, 1'b0, WC, 1'b0, 1'b0, 1'b0, 1'b0);
    check_state("prefill");
    for (int n = 0; n < 80; n++) begin
      int op, idx;
      logic [22:0] a;
      op  = $urandom_range(0, 9);
      idx = $urandom_range(0, 15);
      a   = {13'($urandom), 10'(idx)};
      if (op <= 3)
        do_write(a, 16'($urandom), 1'($urandom), 1'($urandom), $urandom_range(4, 17),
                 1'b0, 1'($urandom), 1'b0, ($urandom_range(0, 15) == 0));
      else if (op == 4)
        do_write(23'($urandom), 16'h0, 1'b0, 1'b0, $urandom_range(4, 10),
                 1'b1, 1'b0, 1'b0, 1'b0);
      else if (op <= 8)
        do_read(a, $urandom_range(0, 3), -1, 1'b0, 1'b0);
      else
        do_read(a, $urandom_range(0, 3), (idx + 1 + $urandom_range(0, 14)) % 16, 1'b0, 1'b0);
      check_state("rand");
    end

    repeat (3) step();
    chk("reads_outstanding", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
